// File: rtl/acc_cpu_pkg.sv
// Purpose: shared opcode/state encodings for the parametrised accumulator CPU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_cpu_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOADIR = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_e;

    // Opcodes that read data memory in EXEC and update acc in WB.
    function automatic logic is_mem_read_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Purpose: accumulator ALU producing the WB value for ADD/AND/XOR/LDA.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] rdata,
    input  opcode_e           opcode,
    output logic [DATA_W-1:0] result
);

    // Select the new accumulator value; ADD drops the carry, other opcodes keep acc.
    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + rdata;
            OP_AND:  result = acc & rdata;
            OP_XOR:  result = acc ^ rdata;
            OP_LDA:  result = rdata;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// Purpose: multi-cycle accumulator CPU core with external sync-read instruction/data memories; PERF_CNT_EN adds a retired-instruction counter.
// Latency: ALU/LDA 4 cycles, STO/JMP/SKZ 3 cycles, HLT 3 cycles to halt; resumes from HALTED the cycle after start.
// Backpressure: none; memories have fixed one-cycle read latency and start is only honoured while halted.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    imem_en,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [OPC_W+ADDR_W-1:0] imem_rdata,
    output logic                    dmem_en,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]       dmem_wdata,
    input  logic [DATA_W-1:0]       dmem_rdata,
    output logic                    halt,
    output logic [ADDR_W-1:0]       pc_o,
    output logic [DATA_W-1:0]       acc_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]             instr_count
`endif
);

    localparam int IW = OPC_W + ADDR_W;

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] alu_result;
    opcode_e           ir_op;
    logic [ADDR_W-1:0] ir_operand;

    assign ir_op      = opcode_e'(ir[IW-1 -: OPC_W]);
    assign ir_operand = ir[ADDR_W-1:0];

    assign imem_addr  = pc;
    assign dmem_addr  = ir_operand;
    assign dmem_wdata = acc;
    assign pc_o       = pc;
    assign acc_o      = acc;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc    (acc),
        .rdata  (dmem_rdata),
        .opcode (ir_op),
        .result (alu_result)
    );

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next-state sequencing; only memory-reading ops take the WB cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   state_nxt = LOADIR;
            LOADIR:  state_nxt = EXEC;
            EXEC: begin
                if (is_mem_read_op(ir_op)) state_nxt = WB;
                else if (ir_op == OP_HLT)  state_nxt = HALTED;
                else                       state_nxt = FETCH;
            end
            WB:      state_nxt = FETCH;
            HALTED:  state_nxt = start ? FETCH : HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    // Memory strobes, decoded from state/ir and suppressed during reset so a STO in flight cannot write.
    always_comb begin
        imem_en = 1'b0;
        dmem_en = 1'b0;
        dmem_we = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: imem_en = 1'b1;
                EXEC: begin
                    if (is_mem_read_op(ir_op)) begin
                        dmem_en = 1'b1;
                    end else if (ir_op == OP_STO) begin
                        dmem_en = 1'b1;
                        dmem_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered halt flag tracks entry into and exit from HALTED.
    always_ff @(posedge clk) begin
        if (rst) halt <= 1'b0;
        else     halt <= (state_nxt == HALTED);
    end

    // pc, ir and acc updates; pc arithmetic wraps at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
        end else begin
            case (state)
                LOADIR: ir <= imem_rdata;
                EXEC: begin
                    case (ir_op)
                        OP_STO, OP_HLT: pc <= pc + ADDR_W'(1);
                        OP_JMP:         pc <= ir_operand;
                        OP_SKZ:         pc <= (acc == '0) ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
                        default: ;
                    endcase
                end
                WB: begin
                    acc <= alu_result;
                    pc  <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic retire;

    // An instruction retires on leaving WB, or on leaving EXEC for FETCH/HALTED.
    assign retire = (state == WB) || ((state == EXEC) && (state_nxt != WB));

    // Free-running retired-instruction count, wraps at 2**32 and holds while halted.
    always_ff @(posedge clk) begin
        if (rst)         instr_count <= '0;
        else if (retire) instr_count <= instr_count + 32'd1;
    end
`else
    // Counter not built: no extra port or state.
`endif

endmodule

// File: tb/tb_acc_cpu_param.sv
module tb_acc_cpu_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int IW     = 3 + ADDR_W;

    localparam logic [2:0] C_HLT = 3'b000;
    localparam logic [2:0] C_SKZ = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_LDA = 3'b101;
    localparam logic [2:0] C_STO = 3'b110;
    localparam logic [2:0] C_JMP = 3'b111;

    logic              clk;
    logic              rst;
    logic              start;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [IW-1:0]     imem_rdata;
    logic              dmem_en;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              halt;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] acc_o;
`ifdef PERF_CNT_EN
    logic [31:0]       instr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [IW-1:0]     prog  [32];
    logic [DATA_W-1:0] dinit [32];
    logic [DATA_W-1:0] dmem  [32];
    logic              load;

    logic [ADDR_W-1:0]        exp_fetch [$];
    logic [ADDR_W-1:0]        obs_fetch [$];
    logic [ADDR_W+DATA_W-1:0] exp_wr    [$];
    logic [ADDR_W+DATA_W-1:0] obs_wr    [$];

    acc_cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .halt       (halt),
        .pc_o       (pc_o),
        .acc_o      (acc_o)
`ifdef PERF_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories; dmem is (re)initialised from dinit on load.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= prog[imem_addr];
        if (load) begin
            for (int i = 0; i < 32; i++) dmem[i] <= dinit[i];
        end else if (dmem_en) begin
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
            else         dmem_rdata <= dmem[dmem_addr];
        end
    end

    // Record what the DUT does, away from the active edge.
    always @(negedge clk) begin
        if (imem_en === 1'b1) obs_fetch.push_back(imem_addr);
        if (dmem_en === 1'b1 && dmem_we === 1'b1) obs_wr.push_back({dmem_addr, dmem_wdata});
    end

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [ADDR_W-1:0] a);
        return {op, a};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            prog[i]  = ins(C_HLT, 5'd0);
            dinit[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        obs_fetch.delete(); obs_wr.delete();
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (halt !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halt !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_timeout: halt=%b after %0d cycles, required 1", name, halt, n);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1; start = 1'b0; load = 1'b1;
        cyc();
        load = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || dmem_en !== 1'b0 || dmem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: imem_en=%b dmem_en=%b dmem_we=%b, required 0", imem_en, dmem_en, dmem_we);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_o !== 5'd0 || acc_o !== 8'h00 || halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h acc=%h halt=%b, required 0/0/0", pc_o, acc_o, halt);
        end
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_first_fetch: imem_en=%b addr=%h, required 1/00", imem_en, imem_addr);
        end
    endtask

    task automatic test_lda_add_wrap();
        logic [ADDR_W-1:0] e, o;
        clear_mem();
        prog[0] = ins(C_LDA, 5'd3);
        prog[1] = ins(C_ADD, 5'd4);
        prog[2] = ins(C_HLT, 5'd0);
        prog[3] = ins(C_LDA, 5'd5);
        prog[4] = ins(C_HLT, 5'd0);
        dinit[3] = 8'hF0; dinit[4] = 8'h20; dinit[5] = 8'h3C;
        do_reset();
        exp_fetch.push_back(5'd0); exp_fetch.push_back(5'd1); exp_fetch.push_back(5'd2);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 11) begin
                checks++;
                if (halt !== 1'b0) begin
                    errors++;
                    $display("FAIL lda_add_early_halt: halt=%b after 10 cycles, required 0", halt);
                end
            end
        end
        checks++;
        if (halt !== 1'b1 || acc_o !== 8'h10 || pc_o !== 5'd3) begin
            errors++;
            $display("FAIL lda_add_result: halt=%b acc=%h pc=%h, required 1/10/03", halt, acc_o, pc_o);
        end
        while (exp_fetch.size() > 0) begin
            e = exp_fetch.pop_front();
            checks++;
            if (obs_fetch.size() == 0) begin
                errors++;
                $display("FAIL lda_add_fetch: got none, required %h", e);
            end else begin
                o = obs_fetch.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL lda_add_fetch: got %h, required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_fetch.size() != 0) begin
            errors++;
            $display("FAIL lda_add_extra_fetch: %0d extra, required 0", obs_fetch.size());
        end
    endtask

    // Continues from the HALTED state left by test_lda_add_wrap (pc=3).
    task automatic test_halt_resume();
        logic [ADDR_W-1:0] e, o;
        int bad;
        obs_fetch.delete();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_en !== 1'b0 || dmem_en !== 1'b0 || halt !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_idle: %0d bad cycles (strobe or halt low), required 0", bad);
        end
        cyc();
        start = 1'b1;
        exp_fetch.push_back(5'd3); exp_fetch.push_back(5'd4);
        cyc();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (halt !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 5'd3) begin
            errors++;
            $display("FAIL resume: halt=%b imem_en=%b addr=%h, required 0/1/03", halt, imem_en, imem_addr);
        end
        cyc(); cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_halt("resume");
        checks++;
        if (pc_o !== 5'd5 || acc_o !== 8'h3C) begin
            errors++;
            $display("FAIL resume_result: pc=%h acc=%h, required 05/3c", pc_o, acc_o);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halt !== 1'b1 || imem_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL start_not_queued: %0d cycles left halt, required 0", bad);
        end
        while (exp_fetch.size() > 0) begin
            e = exp_fetch.pop_front();
            checks++;
            if (obs_fetch.size() == 0) begin
                errors++;
                $display("FAIL resume_fetch: got none, required %h", e);
            end else begin
                o = obs_fetch.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL resume_fetch: got %h, required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_fetch.size() != 0) begin
            errors++;
            $display("FAIL resume_extra_fetch: %0d extra, required 0", obs_fetch.size());
        end
    endtask

    task automatic test_skz();
        logic [ADDR_W-1:0] e, o;
        for (int r = 0; r < 2; r++) begin
            clear_mem();
            prog[0] = ins(C_LDA, 5'd20);
            prog[1] = ins(C_JMP, 5'd5);
            prog[5] = ins(C_SKZ, 5'd0);
            dinit[20] = (r == 0) ? 8'h00 : 8'h01;
            do_reset();
            exp_fetch.push_back(5'd0); exp_fetch.push_back(5'd1); exp_fetch.push_back(5'd5);
            exp_fetch.push_back((r == 0) ? 5'd7 : 5'd6);
            wait_halt("skz");
            checks++;
            if (pc_o !== ((r == 0) ? 5'd8 : 5'd7)) begin
                errors++;
                $display("FAIL skz_pc r=%0d: pc=%h, required %h", r, pc_o, (r == 0) ? 5'd8 : 5'd7);
            end
            while (exp_fetch.size() > 0) begin
                e = exp_fetch.pop_front();
                checks++;
                if (obs_fetch.size() == 0) begin
                    errors++;
                    $display("FAIL skz_fetch r=%0d: got none, required %h", r, e);
                end else begin
                    o = obs_fetch.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL skz_fetch r=%0d: got %h, required %h", r, o, e);
                    end
                end
            end
        end
    endtask

    task automatic test_sto_jmp_wrap();
        logic [ADDR_W-1:0]        e, o;
        logic [ADDR_W+DATA_W-1:0] we, wo;
        logic [ADDR_W-1:0]        seq_a [7];
        logic [ADDR_W-1:0]        seq_b [5];
        seq_a = '{5'd0, 5'd2, 5'd3, 5'd30, 5'd31, 5'd0, 5'd1};
        seq_b = '{5'd0, 5'd2, 5'd31, 5'd0, 5'd1};
        for (int r = 0; r < 2; r++) begin
            clear_mem();
            dinit[10] = 8'hA5;
            prog[0] = ins(C_SKZ, 5'd0);
            prog[1] = ins(C_HLT, 5'd0);
            if (r == 0) begin
                prog[2]  = ins(C_LDA, 5'd10);
                prog[3]  = ins(C_JMP, 5'd30);
                prog[30] = ins(C_STO, 5'd9);
                prog[31] = ins(C_JMP, 5'd0);
                for (int i = 0; i < 7; i++) exp_fetch.push_back(seq_a[i]);
                exp_wr.push_back({5'd9, 8'hA5});
            end else begin
                prog[2]  = ins(C_JMP, 5'd31);
                prog[31] = ins(C_LDA, 5'd10);
                for (int i = 0; i < 5; i++) exp_fetch.push_back(seq_b[i]);
            end
            do_reset();
            wait_halt("sto_jmp");
            checks++;
            if (pc_o !== 5'd2 || acc_o !== 8'hA5) begin
                errors++;
                $display("FAIL sto_jmp_final r=%0d: pc=%h acc=%h, required 02/a5", r, pc_o, acc_o);
            end
            while (exp_fetch.size() > 0) begin
                e = exp_fetch.pop_front();
                checks++;
                if (obs_fetch.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_fetch r=%0d: got none, required %h", r, e);
                end else begin
                    o = obs_fetch.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL wrap_fetch r=%0d: got %h, required %h", r, o, e);
                    end
                end
            end
            while (exp_wr.size() > 0) begin
                we = exp_wr.pop_front();
                checks++;
                if (obs_wr.size() == 0) begin
                    errors++;
                    $display("FAIL sto_write: got none, required addr/data %h", we);
                end else begin
                    wo = obs_wr.pop_front();
                    if (wo !== we) begin
                        errors++;
                        $display("FAIL sto_write: got addr/data %h, required %h", wo, we);
                    end
                end
            end
            checks++;
            if (obs_wr.size() != 0) begin
                errors++;
                $display("FAIL sto_write_cycles r=%0d: %0d extra write cycles, required 0", r, obs_wr.size());
            end
        end
        checks++;
        if (dmem[9] !== 8'h00) begin
            errors++;
            $display("FAIL no_sto_run_mem: mem[9]=%h, required 00", dmem[9]);
        end
    endtask

    task automatic test_reset_mid_sto();
        logic [ADDR_W+DATA_W-1:0] wo;
        clear_mem();
        dinit[10] = 8'hA5;
        prog[0] = ins(C_LDA, 5'd10);
        prog[1] = ins(C_STO, 5'd9);
        prog[2] = ins(C_JMP, 5'd2);
        do_reset();
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_we !== 1'b0 || dmem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_sto_strobe: dmem_en=%b dmem_we=%b, required 0/0", dmem_en, dmem_we);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_o !== 5'd0 || acc_o !== 8'h00 || obs_wr.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_sto_state: pc=%h acc=%h writes=%0d, required 00/00/0", pc_o, acc_o, obs_wr.size());
        end
`ifdef PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_count: instr_count=%0d, required 0", instr_count);
        end
`endif
        for (int i = 2; i <= 12; i++) @(negedge clk);
        checks++;
        if (pc_o !== 5'd2 || acc_o !== 8'hA5) begin
            errors++;
            $display("FAIL post_rst_run: pc=%h acc=%h, required 02/a5", pc_o, acc_o);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (instr_count !== 32'd3) begin
            errors++;
            $display("FAIL retired_count: instr_count=%0d, required 3", instr_count);
        end
`endif
        checks++;
        if (obs_wr.size() != 1) begin
            errors++;
            $display("FAIL post_rst_write_count: %0d writes, required 1", obs_wr.size());
        end else begin
            wo = obs_wr.pop_front();
            if (wo !== {5'd9, 8'hA5}) begin
                errors++;
                $display("FAIL post_rst_write: got addr/data %h, required %h", wo, {5'd9, 8'hA5});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load = 1'b0;
        test_reset();
        test_lda_add_wrap();
        test_halt_resume();
        test_skz();
        test_sto_jmp_wrap();
        test_reset_mid_sto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
